universal_reg: RTL
==================

UNIVERSAL_REG -- requirements
Module: universal_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, register width in bits (legal range 2..32).
REQ-002 SHALL provide parameter RESET_VAL, default 0, value loaded into q on reset (WIDTH bits).
REQ-003 SHALL provide port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port set  input  1  synchronous preset, forces q to all ones.
REQ-006 SHALL provide port en  input  1  operation enable; 0 = hold.
REQ-007 SHALL provide port mode  input  3  operation select when en=1.
REQ-008 SHALL provide port d  input  WIDTH  parallel load data.
REQ-009 SHALL provide port sin  input  1  serial input for shift modes.
REQ-010 SHALL provide port q  output  WIDTH  registered contents.
REQ-011 SHALL provide port sout  output  1  registered copy of the last bit shifted or rotated out.
REQ-012 SHALL provide port zero  output  1  combinational flag, 1 when q == 0.
REQ-013 SHALL provide port wrap  output  1  registered one-cycle pulse on counter wrap-around.

Function
REQ-014 Priority per edge SHALL be reset > set > en=0 (hold) > mode.
REQ-015 mode 000 SHALL hold q.
REQ-016 mode 001 SHALL load q <= d.
REQ-017 mode 010 SHALL shift left: q <= {q[WIDTH-2:0], sin}; sout <= old q[WIDTH-1].
REQ-018 mode 011 SHALL shift right: q <= {sin, q[WIDTH-1:1]}; sout <= old q[0].
REQ-019 mode 100 SHALL rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sout <= old q[WIDTH-1].
REQ-020 mode 101 SHALL rotate right: q <= {q[0], q[WIDTH-1:1]}; sout <= old q[0].
REQ-021 mode 110 SHALL increment q modulo 2^WIDTH; mode 111 SHALL decrement q modulo 2^WIDTH (when counter feature compiled in).
REQ-022 wrap SHALL be 1 for exactly the cycle after an increment from all ones to 0 or a decrement from 0 to all ones; 0 after every other edge.
REQ-023 sout SHALL hold its value on any edge that is not a shift/rotate operation, except reset and set.
REQ-024 Latency: q, sout, wrap SHALL reflect an operation one clock edge after it is sampled; zero SHALL follow q combinationally.
REQ-025 set=1 SHALL force q to all ones, sout to 0, wrap to 0, regardless of en and mode.
REQ-026 Inputs sampled with en=0 (d, sin, mode) SHALL have no effect; wrap SHALL be 0 after a hold edge.

Reset
REQ-027 On a rising edge with reset=1: q <= RESET_VAL, sout <= 0, wrap <= 0; zero = (RESET_VAL == 0).
REQ-028 Reset asserted mid-operation (e.g. during counting or shifting) SHALL abort it on that edge with no residual effect on later cycles.
REQ-029 Reset SHALL have no asynchronous effect; outputs change only on clk rising edges.

Configuration
REQ-030 Macro UNIVERSAL_REG_COUNTER_EN SHALL compile in modes 110/111 and the wrap logic.
REQ-031 Without UNIVERSAL_REG_COUNTER_EN, modes 110/111 SHALL behave as hold and wrap SHALL be tied to 0; all other behaviour SHALL be identical.

Verification (WIDTH=4, RESET_VAL=0)
REQ-032 reset=1 one edge, then en=1 mode=001 d=4'b1010 -> q=0000 zero=1 after reset; q=1010 zero=0 next edge.
REQ-033 q=1001, en=1 mode=010 sin=0 for two edges -> q=0010 sout=1, then q=0100 sout=0.
REQ-034 q=0001, mode=101 one edge -> q=1000 sout=1; then mode=100 one edge -> q=0001 sout=1.
REQ-035 counter built in: q=1110, mode=110 for three edges -> q=1111 wrap=0, q=0000 wrap=1 zero=1, q=0001 wrap=0; mode=111 from 0000 -> q=1111 wrap=1.
REQ-036 set=1 and reset=1 together with en=1 mode=001 d=0101 -> q=0000; set=1 alone -> q=1111 sout=0; en=0 with mode=001 d=0101 -> q unchanged.
REQ-037 counter compiled out: q=0011, mode=110 for two edges -> q=0011, wrap=0 throughout.

Source files
------------

// File: rtl/universal_reg.sv
// Universal register: load, shift/rotate with serial out, optional up/down counter with wrap pulse.
// All outputs registered (one edge of latency) except zero; define UNIVERSAL_REG_COUNTER_EN to build modes 110/111.
module universal_reg #(
   parameter int unsigned     WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             zero,
   output logic             wrap
);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_INC  = 3'b110,
      MODE_DEC  = 3'b111
   } mode_e;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_q, q_d;
   logic             sout_q, sout_d;
   logic             wrap_q, wrap_d;
   mode_e            mode_sel;

   assign mode_sel = mode_e'(mode);

   // wrap defaults to 0 so it is a single-cycle pulse; sout only moves on shift/rotate.
   always_comb begin
      q_d    = q_q;
      sout_d = sout_q;
      wrap_d = 1'b0;
      if (en) begin
         case (mode_sel)
            MODE_LOAD: q_d = d;
            MODE_SHL: begin
               q_d    = {q_q[WIDTH-2:0], sin};
               sout_d = q_q[WIDTH-1];
            end
            MODE_SHR: begin
               q_d    = {sin, q_q[WIDTH-1:1]};
               sout_d = q_q[0];
            end
            MODE_ROL: begin
               q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               sout_d = q_q[WIDTH-1];
            end
            MODE_ROR: begin
               q_d    = {q_q[0], q_q[WIDTH-1:1]};
               sout_d = q_q[0];
            end
`ifdef UNIVERSAL_REG_COUNTER_EN
            MODE_INC: begin
               q_d    = q_q + ONE;
               wrap_d = &q_q;
            end
            MODE_DEC: begin
               q_d    = q_q - ONE;
               wrap_d = ~|q_q;
            end
`endif
            default: begin
               q_d = q_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q    <= RESET_VAL;
         sout_q <= 1'b0;
         wrap_q <= 1'b0;
      end else if (set) begin
         q_q    <= '1;
         sout_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         sout_q <= sout_d;
         wrap_q <= wrap_d;
      end
   end

   assign q    = q_q;
   assign sout = sout_q;
   assign zero = (q_q == '0);
`ifdef UNIVERSAL_REG_COUNTER_EN
   assign wrap = wrap_q;
`else
   assign wrap = 1'b0;
`endif

endmodule
